// File: rtl/noc_router_in_port_if.sv
// Handshake bundle of one router input port: the upstream link side and the
// directed request/grant side consumed by the output arbiters.
interface noc_router_in_port_if #(
  parameter int WIDTH = 35
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [4:0]       out_req;
  logic [4:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic             drop_pulse;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_req, out_data, drop_pulse
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_req, out_data, drop_pulse
  );
endinterface

// File: rtl/noc_router_in_port.sv
// 2D-mesh router input port: DEPTH-entry FIFO, XY route of the head, one-hop header
// update and a registered one-hot output stage. Define NOC_DROP_CNT_EN for drop_cnt.
module noc_router_in_port #(
  parameter int WIDTH  = 35,
  parameter int AW     = 2,
  parameter int DEPTH  = 4,
  parameter int IN_DIR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef NOC_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  noc_router_in_port_if.slave  bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_E  = 3'd1,
    DIR_S  = 3'd2,
    DIR_W  = 3'd3,
    DIR_PE = 3'd4
  } dir_e;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } stage_e;

  localparam bit   CAN_UTURN = (IN_DIR < 4);
  localparam dir_e IN_DIR_E  = dir_e'(3'(IN_DIR));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             wr_en;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [AW-1:0]    cur_x;
  logic [AW-1:0]    cur_y;
  logic [AW-1:0]    dst_x;
  logic [AW-1:0]    dst_y;
  logic [AW-1:0]    nxt_x;
  logic [AW-1:0]    nxt_y;
  dir_e             dir;
  logic             illegal;
  logic             hs;
  logic             can_take;
  logic             load;
  stage_e           state;
  stage_e           state_nxt;
  logic [4:0]       req_q;
  logic [WIDTH-1:0] data_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign wr_en      = bus.in_valid && !fifo_full;
  assign bus.in_ready = !fifo_full;

  assign head = mem[rd_ptr[PW-2:0]];
  assign {cur_x, cur_y, dst_x, dst_y} = head[WIDTH-1 -: 4*AW];

  always_comb begin
    dir   = DIR_PE;
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (dst_x > cur_x) begin
      dir   = DIR_E;
      nxt_x = cur_x + AW'(1);
    end else if (dst_x < cur_x) begin
      dir   = DIR_W;
      nxt_x = cur_x - AW'(1);
    end else if (dst_y > cur_y) begin
      dir   = DIR_N;
      nxt_y = cur_y + AW'(1);
    end else if (dst_y < cur_y) begin
      dir   = DIR_S;
      nxt_y = cur_y - AW'(1);
    end
  end

  assign illegal = CAN_UTURN && (dir == IN_DIR_E);

  // The head is inspected whenever the stage is empty or being drained this edge;
  // an illegal head is popped without being loaded.
  assign hs       = (state == ST_FULL) && |(req_q & bus.out_ready);
  assign can_take = (state == ST_EMPTY) || hs;
  assign pop      = can_take && !fifo_empty;
  assign load     = pop && !illegal;
  assign bus.drop_pulse = pop && illegal;

  assign bus.out_req  = req_q;
  assign bus.out_data = data_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (load)        state_nxt = ST_FULL;
      ST_FULL:  if (hs && !load) state_nxt = ST_EMPTY;
      default:                   state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (load) begin
        req_q  <= 5'b00001 << dir;
        data_q <= {nxt_x, nxt_y, head[WIDTH-1-2*AW:0]};
      end else if (hs) begin
        req_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-2:0]] <= bus.in_data;
  end

`ifdef NOC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.drop_pulse && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
